// File: rtl/program_counter_ctrl.sv
// Fetch-address generator: BOOT/RUN/REDIRECT/HALT sequencer with valid/ready fetch handshake.
// Optional feature macro PC_COMPRESSED_EN adds is_compressed (2-byte steps, 2-byte target alignment).
module program_counter_ctrl #(
  parameter int unsigned          WORDSIZE     = 64,
  parameter logic [WORDSIZE-1:0]  RESET_VECTOR = {WORDSIZE{1'b0}},
  parameter int unsigned          INSTR_BYTES  = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                fetch_ready,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [WORDSIZE-1:0] branch_target,
  input  logic                trap,
  input  logic [WORDSIZE-1:0] trap_vector,
  input  logic                halt_req,
  input  logic                resume,
`ifdef PC_COMPRESSED_EN
  input  logic                is_compressed,
`endif
  output logic [WORDSIZE-1:0] addr,
  output logic                addr_valid,
  output logic                misaligned,
  output logic                halted
);

  typedef enum logic [1:0] {
    ST_BOOT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_REDIRECT = 2'd2,
    ST_HALT     = 2'd3
  } state_e;

  localparam logic [WORDSIZE-1:0] STEP_FULL = WORDSIZE'(INSTR_BYTES);
`ifdef PC_COMPRESSED_EN
  localparam logic [WORDSIZE-1:0] STEP_HALF  = WORDSIZE'(2);
  localparam logic [WORDSIZE-1:0] ALIGN_MASK = WORDSIZE'(1);
`else
  localparam logic [WORDSIZE-1:0] ALIGN_MASK = WORDSIZE'(INSTR_BYTES - 1);
`endif

  // Clearing the low bits; for INSTR_BYTES=1 the mask is zero and targets pass through.
  function automatic logic [WORDSIZE-1:0] align_target(input logic [WORDSIZE-1:0] target);
    return target & ~ALIGN_MASK;
  endfunction

  function automatic logic is_misaligned(input logic [WORDSIZE-1:0] target);
    return |(target & ALIGN_MASK);
  endfunction

  state_e              state_q, state_d;
  logic [WORDSIZE-1:0] addr_q, addr_d;
  logic                valid_q, valid_d;
  logic                misaligned_q, misaligned_d;
  logic                halted_q, halted_d;

  logic [WORDSIZE-1:0] step_s;
  logic [WORDSIZE-1:0] target_s;
  logic                redirect_req_s;
  logic                handshake_s;

  // Increment selection and redirect target arbitration (trap wins over branch).
  always_comb begin
`ifdef PC_COMPRESSED_EN
    step_s = is_compressed ? STEP_HALF : STEP_FULL;
`else
    step_s = STEP_FULL;
`endif
    target_s    = trap ? trap_vector : branch_target;
    handshake_s = valid_q && fetch_ready;
    case (state_q)
      ST_HALT: redirect_req_s = trap;
      default: redirect_req_s = trap || branch_taken;
    endcase
  end

  // State and registered-output flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_BOOT;
      addr_q       <= RESET_VECTOR;
      valid_q      <= 1'b0;
      misaligned_q <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      valid_q      <= valid_d;
      misaligned_q <= misaligned_d;
      halted_q     <= halted_d;
    end
  end

  // Next-state and next-address logic.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    misaligned_d = 1'b0;
    if (redirect_req_s) begin
      addr_d       = align_target(target_s);
      misaligned_d = is_misaligned(target_s);
      state_d      = ST_REDIRECT;
    end else begin
      case (state_q)
        ST_BOOT: begin
          state_d = ST_RUN;
        end
        ST_RUN: begin
          if (halt_req) begin
            if (handshake_s) begin
              addr_d = addr_q + step_s;
            end else begin
              addr_d = addr_q;
            end
            state_d = ST_HALT;
          end else if (stall) begin
            addr_d = addr_q;
          end else if (handshake_s) begin
            addr_d = addr_q + step_s;
          end else begin
            addr_d = addr_q;
          end
        end
        ST_REDIRECT: begin
          state_d = ST_RUN;
        end
        ST_HALT: begin
          if (resume) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_HALT;
          end
        end
        default: begin
          state_d = ST_BOOT;
          addr_d  = RESET_VECTOR;
        end
      endcase
    end
  end

  // Output decode from the next state so the flags are registered with the state.
  always_comb begin
    case (state_d)
      ST_RUN: begin
        valid_d  = 1'b1;
        halted_d = 1'b0;
      end
      ST_HALT: begin
        valid_d  = 1'b0;
        halted_d = 1'b1;
      end
      default: begin
        valid_d  = 1'b0;
        halted_d = 1'b0;
      end
    endcase
  end

  assign addr       = addr_q;
  assign addr_valid = valid_q;
  assign misaligned = misaligned_q;
  assign halted     = halted_q;

endmodule

// File: tb/tb_program_counter_ctrl.sv
// Directed self-checking bench for program_counter_ctrl (WORDSIZE=64, RESET_VECTOR=0, INSTR_BYTES=4).
module tb_program_counter_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        fetch_ready, stall, branch_taken, trap, halt_req, resume;
  logic [63:0] branch_target, trap_vector;
  logic [63:0] addr;
  logic        addr_valid, misaligned, halted;
`ifdef PC_COMPRESSED_EN
  logic        is_compressed;
`endif

  int checks = 0;
  int errors = 0;

  program_counter_ctrl #(
    .WORDSIZE     (64),
    .RESET_VECTOR (64'h0),
    .INSTR_BYTES  (4)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .fetch_ready   (fetch_ready),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .trap          (trap),
    .trap_vector   (trap_vector),
    .halt_req      (halt_req),
    .resume        (resume),
`ifdef PC_COMPRESSED_EN
    .is_compressed (is_compressed),
`endif
    .addr          (addr),
    .addr_valid    (addr_valid),
    .misaligned    (misaligned),
    .halted        (halted)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [63:0] e_addr, input logic e_valid,
                            input logic e_mis, input logic e_halt);
    checks++;
    if (addr !== e_addr || addr_valid !== e_valid || misaligned !== e_mis || halted !== e_halt) begin
      errors++;
      $display("FAIL %s: got addr=%h valid=%b mis=%b halted=%b, expected addr=%h valid=%b mis=%b halted=%b",
               name, addr, addr_valid, misaligned, halted, e_addr, e_valid, e_mis, e_halt);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; fetch_ready = 1'b1; stall = 1'b0; branch_taken = 1'b0; trap = 1'b0;
    halt_req = 1'b0; resume = 1'b0; branch_target = 64'h0; trap_vector = 64'h0;
`ifdef PC_COMPRESSED_EN
    is_compressed = 1'b0;
`endif
    tick; tick;
    expect_out("reset_state", 64'h0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    #1;
    expect_out("boot_no_valid", 64'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_sequential;
    tick; expect_out("run_addr0", 64'h0, 1'b1, 1'b0, 1'b0);
    tick; expect_out("run_addr4", 64'h4, 1'b1, 1'b0, 1'b0);
    tick; expect_out("run_addr8", 64'h8, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure;
    fetch_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick; expect_out("not_ready_hold", 64'h8, 1'b1, 1'b0, 1'b0);
    end
    fetch_ready = 1'b1;
    tick; expect_out("ready_resumes", 64'hC, 1'b1, 1'b0, 1'b0);
    stall = 1'b1;
    tick; expect_out("stall_hold", 64'hC, 1'b1, 1'b0, 1'b0);
    stall = 1'b0;
    tick; expect_out("stall_release", 64'h10, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_trap_over_branch;
    branch_taken = 1'b1; branch_target = 64'h100; trap = 1'b1; trap_vector = 64'h200;
    tick; expect_out("trap_wins_bubble", 64'h200, 1'b0, 1'b0, 1'b0);
    branch_taken = 1'b0; trap = 1'b0;
    tick; expect_out("trap_target_valid", 64'h200, 1'b1, 1'b0, 1'b0);
    tick; expect_out("trap_target_next", 64'h204, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_misaligned;
    branch_taken = 1'b1; branch_target = 64'h102;
    tick;
`ifdef PC_COMPRESSED_EN
    expect_out("misaligned_pulse", 64'h102, 1'b0, 1'b0, 1'b0);
`else
    expect_out("misaligned_pulse", 64'h100, 1'b0, 1'b1, 1'b0);
`endif
    branch_taken = 1'b0;
    tick;
`ifdef PC_COMPRESSED_EN
    expect_out("misaligned_clear", 64'h102, 1'b1, 1'b0, 1'b0);
`else
    expect_out("misaligned_clear", 64'h100, 1'b1, 1'b0, 1'b0);
`endif
  endtask

  task automatic test_halt;
    branch_taken = 1'b1; branch_target = 64'h10;
    tick; branch_taken = 1'b0;
    tick; expect_out("halt_setup", 64'h10, 1'b1, 1'b0, 1'b0);
    halt_req = 1'b1;
    tick; expect_out("halt_enter", 64'h14, 1'b0, 1'b0, 1'b1);
    halt_req = 1'b0; branch_taken = 1'b1; branch_target = 64'h400;
    tick; expect_out("halt_ignores_branch", 64'h14, 1'b0, 1'b0, 1'b1);
    branch_taken = 1'b0; resume = 1'b1;
    tick; expect_out("resume_run", 64'h14, 1'b1, 1'b0, 1'b0);
    resume = 1'b0;
    tick; expect_out("resume_next", 64'h18, 1'b1, 1'b0, 1'b0);
    halt_req = 1'b1;
    tick; expect_out("halt_again", 64'h1C, 1'b0, 1'b0, 1'b1);
    halt_req = 1'b0; trap = 1'b1; trap_vector = 64'h300;
    tick; expect_out("trap_in_halt", 64'h300, 1'b0, 1'b0, 1'b0);
    trap = 1'b0; halt_req = 1'b1;
    tick; tick; expect_out("halt_before_reset", 64'h304, 1'b0, 1'b0, 1'b1);
    halt_req = 1'b0;
    #2 reset_n = 1'b0;
    #1 expect_out("async_reset_in_halt", 64'h0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    tick; expect_out("run_after_reset", 64'h0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_wrap;
    branch_taken = 1'b1; branch_target = 64'hFFFF_FFFF_FFFF_FFFC;
    tick; branch_taken = 1'b0;
    tick; expect_out("wrap_setup", 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b0, 1'b0);
    tick; expect_out("wrap_to_zero", 64'h0, 1'b1, 1'b0, 1'b0);
    tick; expect_out("after_wrap", 64'h4, 1'b1, 1'b0, 1'b0);
  endtask

`ifdef PC_COMPRESSED_EN
  task automatic test_compressed;
    branch_taken = 1'b1; branch_target = 64'h0;
    tick; branch_taken = 1'b0;
    tick; is_compressed = 1'b1;
    tick; expect_out("compressed_step", 64'h2, 1'b1, 1'b0, 1'b0);
    is_compressed = 1'b0;
    tick; expect_out("full_step_after_c", 64'h6, 1'b1, 1'b0, 1'b0);
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_trap_over_branch();
    test_misaligned();
    test_halt();
    test_wrap();
`ifdef PC_COMPRESSED_EN
    test_compressed();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
